addsub_stream_seq: RTL and testbench
====================================

# addsub_stream_seq

Operand sequencer for the Jacobi update datapath. It sits directly upstream of `adder_subtractor`. It accepts a run of element pairs over a valid/ready handshake and drives the adder's A/B/op/ce inputs, one element per enabled cycle. It tracks the fpadd pipeline with a valid/index shift register, so `out_valid`/`out_idx` line up with `result` at the adder output. It also stalls the whole pipeline through `ce` when the downstream consumer is not ready.

## Interface
- `ADD_LAT`, 7: fpadd pipeline depth in ce-enabled cycles; legal range 1..32.
- `IDX_W`, 10: element index width; maximum run length is 2^IDX_W.

Ports:
- `clk`  in  1  — the design's single clock; all state on rising edge.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `start`  in  1  — one-cycle pulse that begins a run; honoured only in IDLE.
- `vec_len`  in  IDX_W+1  — run length; sampled on accepted `start`.
- `in_valid`  in  1  — element pair present.
- `in_ready`  out  1  — block accepts the pair this cycle.
- `in_a`, `in_b`  in  32 each  — IEEE-754 single operands.
- `in_op`  in  1  — 0 = add, 1 = subtract; passed through.
- `add_a`, `add_b`  out  32 each  — to `adder_subtractor` A, B.
- `add_op`  out  1  — to `adder_subtractor` op.
- `add_ce`  out  1  — to `adder_subtractor` ce; pipeline advance enable.
- `out_ready`  in  1  — consumer accepts `result`.
- `out_valid`  out  1  — `result` at the adder output is valid this cycle.
- `out_idx`  out  IDX_W  — element index of the current `result`.
- `busy`  out  1  — state is not IDLE.
- `done`  out  1  — one-cycle pulse when the last result of the run is accepted.

## Operation
- States:
  - IDLE: `start` moves to RUN and loads `len`=`vec_len`, `issued`=0, `retired`=0. If `vec_len`==0, go instead to DONE.
  - RUN: issue elements. When `retired`==`len`, go to DONE.
  - DONE: assert `done` for one cycle, then return to IDLE.
- Stall rule: `add_ce` = !(`vpipe[ADD_LAT-1]` && !`out_ready`). The pipeline freezes only when its head holds a valid result the consumer refuses. Bubbles keep advancing.
- `in_ready` = RUN && `add_ce` && (`issued` < `len`).
- Fire = `in_valid` && `in_ready`.
  - `add_a`/`add_b`/`add_op` are driven combinationally from `in_a`/`in_b`/`in_op`; fpadd registers them internally.
  - When not firing, these outputs are driven to 0.
- Valid pipeline: on each `add_ce`=1 cycle, `vpipe` shifts by one. `vpipe[0]` takes fire, and `ipipe[0]` takes `issued`. On fire, `issued` increments.
- `out_valid` = `vpipe[ADD_LAT-1]`; `out_idx` = `ipipe[ADD_LAT-1]`.
- Retire when `out_valid` && `out_ready`; `retired` increments.
- `start` outside IDLE is ignored. `in_valid` outside RUN is ignored; `in_ready`=0.
- Counters are IDX_W+1 bits wide. `len`=2^IDX_W is legal, and `out_idx` runs 0..2^IDX_W-1 without wrap.

## Timing
- Reset values: `in_ready`, `add_a`, `add_b`, `add_op`, `out_valid`, `out_idx`, `busy` and `done` are all 0. `add_ce`=1, since the pipeline is empty. `vpipe`, `ipipe` and all counters are cleared.
- Reset mid-run aborts immediately:
  - `vpipe` is flushed.
  - Results still inside fpadd are never flagged valid.
- Latency: an element fired in cycle t appears with `out_valid`=1 after exactly ADD_LAT `add_ce`=1 cycles. With no stalls, that is cycle t+ADD_LAT.
- Throughput: one element per cycle when `in_valid` and `out_ready` are held high.
- `done` is asserted in the cycle after the final retire. `busy` falls in the cycle after `done`.
- Simultaneous fire and retire in one cycle is legal. Both counters update.

## Configuration
- `ADDSUB_SEQ_IDX_EN`:
  - Defined: the `ipipe` index shift register is built and `out_idx` is as specified.
  - Undefined: no `ipipe` storage is built and `out_idx` is tied to 0. All other behaviour is identical.

## Test plan
- ADD_LAT=7, `vec_len`=4, `in_valid` and `out_ready` held at 1, fires at cycles 1..4 -> `out_valid` at cycles 8..11 with `out_idx` 0,1,2,3; `done` at cycle 12; `busy` low at 13.
- Same run, but `out_ready`=0 for cycles 9..10 -> `add_ce`=0 and `in_ready`=0 in those cycles; `out_idx`=1 is held until accepted; no result lost or duplicated; `done` 2 cycles later.
- `in_valid` toggling 1,0,1,0 with `vec_len`=2 -> bubbles propagate, `out_valid` pattern matches the input gaps, `in_op`=1 reaches `add_op`.
- `vec_len`=0 -> `done` one cycle after the DONE transition; `in_ready` never asserted; `add_ce` stays 1.
- `start` pulsed during RUN with a different `vec_len` -> ignored; original run length completes.
- `rst_n` dropped after 3 of 5 elements issued -> all outputs go to their reset values immediately. A new `start` with `vec_len`=1 yields exactly one `out_valid`, with `out_idx`=0.

Source files
------------

// File: rtl/addsub_stream_seq.sv
// Operand sequencer feeding adder_subtractor; tracks the fpadd pipeline so out_valid/out_idx line up with result.
// Latency: ADD_LAT ce-enabled cycles from fire to out_valid. Backpressure: out_ready low with a valid head freezes add_ce and in_ready.
// Optional ADDSUB_SEQ_IDX_EN builds the index shift register; otherwise out_idx is tied to 0.
module addsub_stream_seq #(
    parameter int ADD_LAT = 7,
    parameter int IDX_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W:0]   vec_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_op,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_op,
    output logic             add_ce,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state;
    logic [IDX_W:0]     len;
    logic [IDX_W:0]     issued;
    logic [IDX_W:0]     retired;
    logic [IDX_W:0]     retired_nxt;
    logic [ADD_LAT-1:0] vpipe;
    logic               fire;
    logic               retire;

    // Freeze only when the head holds a result the consumer refuses; bubbles keep moving.
    assign add_ce      = !(vpipe[ADD_LAT-1] && !out_ready);
    assign in_ready    = (state == S_RUN) && add_ce && (issued < len);
    assign fire        = in_valid && in_ready;
    assign retire      = vpipe[ADD_LAT-1] && out_ready;
    assign retired_nxt = retired + {{IDX_W{1'b0}}, 1'b1};

    assign add_a     = fire ? in_a : 32'd0;
    assign add_b     = fire ? in_b : 32'd0;
    assign add_op    = fire ? in_op : 1'b0;
    assign out_valid = vpipe[ADD_LAT-1];
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            len     <= '0;
            issued  <= '0;
            retired <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len     <= vec_len;
                        issued  <= '0;
                        retired <= '0;
                        state   <= (vec_len == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        issued <= issued + {{IDX_W{1'b0}}, 1'b1};
                    end
                    // Leave on the final retire edge so done follows it by one cycle.
                    if (retire) begin
                        retired <= retired_nxt;
                        if (retired_nxt == len) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else if (add_ce) begin
            vpipe[0] <= fire;
            for (int i = 1; i < ADD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

`ifdef ADDSUB_SEQ_IDX_EN
    logic [IDX_W-1:0] ipipe [ADD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ADD_LAT; i++) begin
                ipipe[i] <= '0;
            end
        end else if (add_ce) begin
            ipipe[0] <= issued[IDX_W-1:0];
            for (int i = 1; i < ADD_LAT; i++) begin
                ipipe[i] <= ipipe[i-1];
            end
        end
    end

    assign out_idx = ipipe[ADD_LAT-1];
`else
    assign out_idx = '0;
`endif

endmodule

// File: tb/tb_addsub_stream_seq.sv
// Bench for addsub_stream_seq: per-cycle comparison against a queue-based model of in-flight elements.
module tb_addsub_stream_seq;
    localparam int ADD_LAT = 7;
    localparam int IDX_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W:0]   vec_len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic             in_op = 1'b0;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic             add_op;
    logic             add_ce;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             busy;
    logic             done;

    addsub_stream_seq #(.ADD_LAT(ADD_LAT), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_ce(add_ce),
        .out_ready(out_ready), .out_valid(out_valid), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: each in-flight element carries its index and ce cycles elapsed since fire.
    typedef struct {
        int idx;
        int age;
    } ent_t;
    ent_t q[$];
    int m_state;   // 0 idle, 1 run, 2 done
    int m_len, m_iss, m_ret;
    int cyc, acc_cnt, done_cnt, done_at, busy_low_at;

    task automatic model_clear();
        q.delete();
        m_state = 0;
        m_len = 0;
        m_iss = 0;
        m_ret = 0;
    endtask

    task automatic scen_begin();
        cyc = 0;
        acc_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        busy_low_at = -1;
    endtask

    task automatic drive_cycle(input logic st, input int vl, input logic iv, input logic op, input logic ordy);
        logic        head, e_ce, e_ir, e_fire;
        int          hidx;
        logic [31:0] a, b;
        @(negedge clk);
        a = $urandom;
        b = $urandom;
        start = st; vec_len = vl[IDX_W:0]; in_valid = iv;
        in_a = a; in_b = b; in_op = op; out_ready = ordy;
        #1;
        head   = (q.size() > 0) && (q[0].age == ADD_LAT);
        hidx   = head ? q[0].idx : 0;
        e_ce   = !(head && !ordy);
        e_ir   = (m_state == 1) && e_ce && (m_iss < m_len);
        e_fire = iv && e_ir;
        checks++;
        if ({add_ce, in_ready, out_valid, busy, done} !== {e_ce, e_ir, head, (m_state != 0), (m_state == 2)}) begin
            errors++;
            $display("FAIL ctrl cyc=%0d got ce/ir/ov/busy/done=%b%b%b%b%b want %b%b%b%b%b", cyc,
                     add_ce, in_ready, out_valid, busy, done, e_ce, e_ir, head, (m_state != 0), (m_state == 2));
        end
        checks++;
        if ({add_a, add_b, add_op} !== (e_fire ? {a, b, op} : 65'd0)) begin
            errors++;
            $display("FAIL operands cyc=%0d got %h %h %b want fire=%b %h %h %b", cyc, add_a, add_b, add_op, e_fire, a, b, op);
        end
`ifdef ADDSUB_SEQ_IDX_EN
        if (head) begin
            checks++;
            if (out_idx !== hidx[IDX_W-1:0]) begin
                errors++;
                $display("FAIL out_idx cyc=%0d got %0d want %0d", cyc, out_idx, hidx);
            end
        end
`else
        checks++;
        if (out_idx !== '0) begin
            errors++;
            $display("FAIL out_idx_tied cyc=%0d got %0d want 0", cyc, out_idx);
        end
`endif
        if (out_valid === 1'b1 && ordy) acc_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = cyc;
        end
        if (busy === 1'b0 && cyc > 0 && busy_low_at < 0) busy_low_at = cyc;
        if (head && ordy) void'(q.pop_front());
        if (e_ce) for (int i = 0; i < q.size(); i++) q[i].age++;
        if (e_fire) q.push_back('{idx: m_iss, age: 1});
        case (m_state)
            0: if (st) begin
                m_len = vl; m_iss = 0; m_ret = 0;
                m_state = (vl == 0) ? 2 : 1;
            end
            1: begin
                if (e_fire) m_iss++;
                if (head && ordy) begin
                    m_ret++;
                    if (m_ret == m_len) m_state = 2;
                end
            end
            default: m_state = 0;
        endcase
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, add_a, add_b, add_op, out_valid, out_idx, busy, done, add_ce} !== {70'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values got ir=%b a=%h b=%h op=%b ov=%b idx=%0d busy=%b done=%b ce=%b want all 0 and ce=1",
                     in_ready, add_a, add_b, add_op, out_valid, out_idx, busy, done, add_ce);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        scen_begin();
        drive_cycle(1'b1, 4, 1'b1, 1'b0, 1'b1);
        while (m_state != 0 && cyc < 60) drive_cycle(1'b0, 0, 1'b1, 1'(($urandom) & 1), 1'b1);
        drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (done_at != 12 || busy_low_at != 13 || acc_cnt != 4 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_timing done_at=%0d busy_low=%0d accepted=%0d dones=%0d want 12 13 4 1",
                     done_at, busy_low_at, acc_cnt, done_cnt);
        end
    endtask

    task automatic test_stall();
        scen_begin();
        drive_cycle(1'b1, 4, 1'b1, 1'b0, 1'b1);
        while (m_state != 0 && cyc < 60) drive_cycle(1'b0, 0, 1'b1, 1'b0, !(cyc == 9 || cyc == 10));
        checks++;
        if (done_at != 14 || acc_cnt != 4) begin
            errors++;
            $display("FAIL stall done_at=%0d accepted=%0d want 14 4", done_at, acc_cnt);
        end
    endtask

    task automatic test_bubbles();
        scen_begin();
        drive_cycle(1'b1, 2, 1'b0, 1'b1, 1'b1);
        while (m_state != 0 && cyc < 60) drive_cycle(1'b0, 0, 1'(cyc % 2), 1'b1, 1'b1);
        checks++;
        if (done_at != 11 || acc_cnt != 2) begin
            errors++;
            $display("FAIL bubbles done_at=%0d accepted=%0d want 11 2", done_at, acc_cnt);
        end
    endtask

    task automatic test_zero_len();
        scen_begin();
        drive_cycle(1'b1, 0, 1'b1, 1'b0, 1'b1);
        repeat (4) drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (done_at != 1 || done_cnt != 1 || busy_low_at != 2 || acc_cnt != 0) begin
            errors++;
            $display("FAIL zero_len done_at=%0d dones=%0d busy_low=%0d accepted=%0d want 1 1 2 0",
                     done_at, done_cnt, busy_low_at, acc_cnt);
        end
    endtask

    task automatic test_start_ignored();
        scen_begin();
        drive_cycle(1'b1, 3, 1'b1, 1'b0, 1'b1);
        while (m_state != 0 && cyc < 60) drive_cycle(cyc == 2, 9, 1'b1, 1'b0, 1'b1);
        repeat (3) drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (done_at != 11 || acc_cnt != 3 || done_cnt != 1) begin
            errors++;
            $display("FAIL start_ignored done_at=%0d accepted=%0d dones=%0d want 11 3 1", done_at, acc_cnt, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        scen_begin();
        drive_cycle(1'b1, 5, 1'b1, 1'b0, 1'b1);
        repeat (3) drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, add_a, add_b, add_op, out_valid, out_idx, busy, done, add_ce} !== {70'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid got ir=%b op=%b ov=%b idx=%0d busy=%b done=%b ce=%b want all 0 and ce=1",
                     in_ready, add_op, out_valid, out_idx, busy, done, add_ce);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        scen_begin();
        drive_cycle(1'b1, 1, 1'b1, 1'b0, 1'b1);
        while (m_state != 0 && cyc < 60) drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
        repeat (8) drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (acc_cnt != 1 || done_at != 9) begin
            errors++;
            $display("FAIL reset_rerun accepted=%0d done_at=%0d want 1 9", acc_cnt, done_at);
        end
    endtask

    task automatic test_max_len();
        scen_begin();
        drive_cycle(1'b1, 1 << IDX_W, 1'b1, 1'b0, 1'b1);
        while (m_state != 0 && cyc < 100) drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (acc_cnt != (1 << IDX_W) || done_at != (1 << IDX_W) + ADD_LAT + 1) begin
            errors++;
            $display("FAIL max_len accepted=%0d done_at=%0d want %0d %0d", acc_cnt, done_at,
                     1 << IDX_W, (1 << IDX_W) + ADD_LAT + 1);
        end
    endtask

    task automatic test_random();
        int vl;
        for (int r = 0; r < 8; r++) begin
            scen_begin();
            vl = $urandom_range(1, 1 << IDX_W);
            drive_cycle(1'b1, vl, 1'b0, 1'b0, 1'b1);
            while (m_state != 0 && cyc < 400)
                drive_cycle(($urandom % 8) == 0, $urandom_range(0, 1 << IDX_W), ($urandom % 4) != 0,
                            1'(($urandom) & 1), ($urandom % 3) != 0);
            checks++;
            if (m_state != 0 || acc_cnt != vl || done_cnt != 1) begin
                errors++;
                $display("FAIL random_run%0d accepted=%0d dones=%0d state=%0d want %0d 1 0",
                         r, acc_cnt, done_cnt, m_state, vl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_bubbles();
        test_zero_len();
        test_start_ignored();
        test_reset_mid();
        test_max_len();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
